// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared widths and FSM encodings for the sequential multiplier
package mult_pkg;

  localparam int MULT_WIDTH = 32;
  localparam int CNT_W      = 5;

  localparam logic [CNT_W-1:0] CNT_LAST = 5'd31;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/seq_multiplier_adder.sv
// rtl/seq_multiplier_adder.sv - 32-bit ripple adder with carry-in and carry-out
module thirtytwobitadder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        carryin,
  output logic [31:0] sum,
  output logic        carryout
);

  // Full 33-bit result so the carry is never lost
  always_comb begin
    {carryout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, carryin};
  end

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - 32x32 shift-add multiplier, one partial product per cycle
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 invalid,
  output logic                 inready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 outvalid,
  input  logic                 outready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 ovf
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_c;

  // Operand mux: add the multiplicand only when the current multiplier bit is set
  always_comb begin
    add_b = lo_q[0] ? mcand_q : '0;
  end

  thirtytwobitadder u_adder (
    .a        (hi_q),
    .b        (add_b),
    .carryin  (1'b0),
    .sum      (add_sum),
    .carryout (add_c)
  );

  // Next-state logic: accept in IDLE, shift-add in BUSY, hold result in DONE
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (invalid) begin
          mcand_d = a;
          hi_d    = '0;
          lo_d    = b;
          count_d = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // {carry,sum,lo} shifted right by one; the carry lands in the top bit
        hi_d    = {add_c, add_sum[WIDTH-1:1]};
        lo_d    = {add_sum[0], lo_q[WIDTH-1:1]};
        count_d = count_q + 1'b1;
        if (count_q == CNT_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (outready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      count_q <= count_d;
    end
  end

  // Handshake flags and result come straight from the registers
  always_comb begin
    inready  = (state_q == ST_IDLE);
    outvalid = (state_q == ST_DONE);
    product  = {hi_q, lo_q};
    ovf      = |hi_q;
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - scoreboard bench for seq_multiplier
module tb_seq_multiplier;

  logic        clk;
  logic        resetn;
  logic        invalid;
  logic        inready;
  logic [31:0] a;
  logic [31:0] b;
  logic        outvalid;
  logic        outready;
  logic [63:0] product;
  logic        ovf;

  int n_checks;
  int n_fail;
  logic [63:0] exp_q[$];

  seq_multiplier dut (
    .clk      (clk),
    .resetn   (resetn),
    .invalid  (invalid),
    .inready  (inready),
    .a        (a),
    .b        (b),
    .outvalid (outvalid),
    .outready (outready),
    .product  (product),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one accept edge and record the expected product
  task automatic accept(input logic [31:0] aa, input logic [31:0] bb);
    check("inready_before_accept", 64'(inready), 64'd1);
    a       = aa;
    b       = bb;
    invalid = 1'b1;
    exp_q.push_back(64'(aa) * 64'(bb));
    step();
    invalid = 1'b0;
    a       = $urandom;
    b       = $urandom;
    check("inready_after_accept", 64'(inready), 64'd0);
  endtask

  // Wait for the result, compare against the scoreboard, stall, then handshake
  task automatic collect(input string tag, input int hold_cycles);
    int n;
    logic [63:0] exp;
    n = 0;
    while (!outvalid && n < 40) begin
      step();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd32);
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 64'd1, 64'd0);
      return;
    end
    exp = exp_q.pop_front();
    check({tag, "_product"}, product, exp);
    check({tag, "_ovf"}, 64'(ovf), 64'(|exp[63:32]));
    if (hold_cycles > 0) outready = 1'b0;
    for (int i = 0; i < hold_cycles; i++) begin
      step();
      check({tag, "_hold_valid"}, 64'(outvalid), 64'd1);
      check({tag, "_hold_product"}, product, exp);
      check({tag, "_hold_ovf"}, 64'(ovf), 64'(|exp[63:32]));
      check({tag, "_hold_inready"}, 64'(inready), 64'd0);
    end
    outready = 1'b1;
    step();
    outready = 1'b0;
    check({tag, "_idle_valid"}, 64'(outvalid), 64'd0);
    check({tag, "_idle_inready"}, 64'(inready), 64'd1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    resetn   = 1'b0;
    invalid  = 1'b0;
    outready = 1'b0;
    a        = '0;
    b        = '0;
    step();
    step();
    check("reset_inready", 64'(inready), 64'd1);
    check("reset_outvalid", 64'(outvalid), 64'd0);
    check("reset_product", product, 64'd0);
    check("reset_ovf", 64'(ovf), 64'd0);
    resetn = 1'b1;

    // 3*5 with outready held high throughout: ignored until DONE
    outready = 1'b1;
    accept(32'd3, 32'd5);
    collect("small", 0);
    check("small_const", {32'd0, 32'hF}, 64'd3 * 64'd5);

    // All ones: exercises the adder carry into bit 63
    accept(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    collect("allones", 0);

    // Zero multiplicand: same latency
    accept(32'd0, 32'h1234_5678);
    collect("zero", 0);

    // Overflow into the high word with a 10-cycle consumer stall
    accept(32'h8000_0000, 32'd2);
    collect("stall", 10);

    // New operands presented throughout BUSY must be ignored
    accept(32'd11, 32'd13);
    invalid = 1'b1;
    a       = 32'd100;
    b       = 32'd200;
    collect("busy_ignore", 0);
    accept(32'd100, 32'd200);
    collect("after_idle", 0);

    // Abort mid-operation with an asynchronous reset
    accept(32'd7, 32'd9);
    repeat (17) step();
    #2;
    resetn = 1'b0;
    #1;
    check("abort_inready", 64'(inready), 64'd1);
    check("abort_outvalid", 64'(outvalid), 64'd0);
    check("abort_product", product, 64'd0);
    check("abort_ovf", 64'(ovf), 64'd0);
    exp_q.delete();
    step();
    resetn = 1'b1;
    accept(32'd7, 32'd9);
    collect("post_reset", 0);

    // A few random operand pairs
    for (int i = 0; i < 4; i++) begin
      accept($urandom, $urandom);
      collect("random", i);
    end

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
